// File: rtl/truth_table_sweep_ctrl.sv
// ============================================================================
// Module      : truth_table_sweep_ctrl
// Description : Sweeps every input vector of a combinational function unit,
//               captures the F1/F2 truth tables and checks them against masks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweep_ctrl #(
    parameter int N_VARS     = 3,
    parameter int SETTLE_CYC = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic                  abort,
    input  wire logic [(1<<N_VARS)-1:0] exp_f1,
    input  wire logic [(1<<N_VARS)-1:0] exp_f2,
    input  wire logic                  f1_in,
    input  wire logic                  f2_in,
    output logic [N_VARS-1:0]          vec_out,
    output logic                       busy,
    output logic                       done,
    output logic [(1<<N_VARS)-1:0]     tt_f1,
    output logic [(1<<N_VARS)-1:0]     tt_f2,
    output logic                       pass,
    output logic [N_VARS:0]            err_cnt
);

    localparam int                TW         = 1 << N_VARS;
    localparam logic [N_VARS-1:0] c_VEC_LAST = N_VARS'(TW - 1);
    localparam logic [N_VARS-1:0] c_VEC_ONE  = N_VARS'(1);
    localparam logic [N_VARS:0]   c_ERR_ONE  = (N_VARS + 1)'(1);
    localparam logic [3:0]        c_CNT_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [TW-1:0]   r_exp_f1;
    logic [TW-1:0]   r_exp_f2;

    logic [TW-1:0]   w_tt_f1_nxt;
    logic [TW-1:0]   w_tt_f2_nxt;
    logic            w_mismatch;

    // Tables including the vector being sampled now, so pass can be judged
    // on the same edge that writes the last entry.
    always_comb begin
        w_tt_f1_nxt          = tt_f1;
        w_tt_f2_nxt          = tt_f2;
        w_tt_f1_nxt[vec_out] = f1_in;
        w_tt_f2_nxt[vec_out] = f2_in;
        w_mismatch           = (f1_in != r_exp_f1[vec_out]) ||
                               (f2_in != r_exp_f2[vec_out]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_exp_f1 <= '0;
            r_exp_f2 <= '0;
            vec_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tt_f1    <= '0;
            tt_f2    <= '0;
            pass     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        r_exp_f1 <= exp_f1;
                        r_exp_f2 <= exp_f2;
                        tt_f1    <= '0;
                        tt_f2    <= '0;
                        err_cnt  <= '0;
                        pass     <= 1'b0;
                        vec_out  <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_SETTLE;
                    end
                end
                S_SETTLE, S_SAMPLE: begin
                    if (abort) begin
                        vec_out <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        tt_f1   <= '0;
                        tt_f2   <= '0;
                        err_cnt <= '0;
                        pass    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_state == S_SETTLE) begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= S_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else begin
                        tt_f1 <= w_tt_f1_nxt;
                        tt_f2 <= w_tt_f2_nxt;
                        if (w_mismatch) begin
                            err_cnt <= err_cnt + c_ERR_ONE;
                        end
                        if (vec_out == c_VEC_LAST) begin
                            vec_out <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_tt_f1_nxt == r_exp_f1) &&
                                       (w_tt_f2_nxt == r_exp_f2);
                            r_state <= S_DONE;
                        end else begin
                            vec_out <= vec_out + c_VEC_ONE;
                            r_cnt   <= '0;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
